frame_config_loader: RTL and testbench
======================================

Name: frame_config_loader

Overview:
- Configuration-side stage directly upstream of the per-tile frame-latch config memories.
- Accepts a 32-bit configuration word stream over a valid/ready handshake.
- Assembles one full frame column (NumRows × FrameBitsPerRow bits) and drives the shared FrameData bus.
- Pulses a single one-hot FrameStrobe line, with guaranteed data setup/hold around the strobe, so the level-sensitive latches capture cleanly.

Parameters:
- MaxFramesPerCol, 20, width of FrameStrobe; also the upper bound on a legal frame index.
- FrameBitsPerRow, 32, bits per tile row; equals the stream word width.
- NumRows, 4, tile rows in the column; FrameData width = NumRows*FrameBitsPerRow.
- StrobeCycles, 2, FrameStrobe high time in CLK cycles; must be ≥1.
- SyncByte, 8'hA5, required header tag.

Ports:
- CLK  input  1  sole clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- cfg_data  input  32  stream word.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  block accepts the word this cycle.
- err_clr  input  1  synchronous clear of cfg_err.
- FrameData  output  NumRows*FrameBitsPerRow  column frame data to the config memories.
- FrameStrobe  output  MaxFramesPerCol  one-hot latch enable.
- busy  output  1  high in any state other than IDLE.
- cfg_err  output  1  sticky header error.
- frame_count  output  16  frames committed since reset; wraps at 16'hFFFF→0.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE, FrameData=0, FrameStrobe=0, frame_count=0, cfg_err=0, row counter=0, frame index register=0.
  - Reset mid-strobe drops FrameStrobe low immediately, without waiting for CLK.
- Transfer: a word transfers on a rising CLK when cfg_valid && cfg_ready.
- cfg_ready: combinational from state; 1 in IDLE and LOAD, 0 otherwise. It never depends on cfg_valid.
- IDLE: waits for a header word.
  - Legal header: cfg_data[31:24]==SyncByte and cfg_data[4:0] < MaxFramesPerCol.
  - On a legal header: latch idx=cfg_data[4:0], row=0, go to LOAD.
  - On an illegal header: consume the word, set cfg_err=1, stay in IDLE.
  - Bits [23:5] are ignored.
- LOAD: each transferred word is written to FrameData[row*32 +: 32], then row increments.
  - Row 0 is the first data word after the header.
  - When the word for row NumRows-1 transfers, go to SETUP.
  - A stalled cfg_valid holds state indefinitely.
- SETUP: exactly 1 cycle. FrameData is stable and FrameStrobe=0. Go to STROBE.
- STROBE: FrameStrobe = one-hot at idx (bit idx high, all others low) for exactly StrobeCycles cycles, counted by a down-counter. Then go to HOLD.
- HOLD: exactly 1 cycle. FrameStrobe=0 and FrameData unchanged. frame_count increments on entry to HOLD. Go to IDLE.
- FrameData after a frame: retains its last value in IDLE; it is only ever modified during LOAD.
- Minimum frame period: 1 (header) + NumRows + 1 + StrobeCycles + 1 cycles, i.e. 9 cycles at default parameters.
- FrameStrobe: at most one bit high in any cycle, and never high outside STROBE.
- cfg_err: set by an illegal header; cleared by err_clr. If an illegal header and err_clr occur in the same cycle, set wins.
- busy = (state != IDLE).
- Registered outputs: FrameData, FrameStrobe, frame_count and cfg_err are registered. cfg_ready and busy are decoded from the registered state.

Decomposition:
- Shared package cfg_loader_pkg holds:
  - state encoding (IDLE, LOAD, SETUP, STROBE, HOLD);
  - SYNC_BYTE default;
  - header field positions (TAG_MSB/LSB = 31/24, IDX_MSB/LSB = 4/0).
- One natural sub-module, frame_strobe_decoder: registered one-hot decode of idx, gated by an enable. It is shared with future column loaders.

Test Plan:
- Nominal frame: header 32'hA500_0003, data 32'h1111_1111, 2222_2222, 3333_3333, 4444_4444 → FrameData = {44444444,33333333,22222222,11111111}; FrameStrobe == 20'h00008 for exactly 2 cycles, with 1 SETUP cycle before and 1 HOLD cycle after; frame_count=1.
- Bad header: 32'h5A00_0001 then 32'hA500_0014 (idx 20) → both consumed, cfg_err=1, FrameStrobe stays 0, FrameData unchanged. Then err_clr=1 → cfg_err=0.
- Backpressure/stall: cfg_valid toggles every other cycle during LOAD → words land in the correct rows; cfg_ready=0 throughout SETUP/STROBE/HOLD while cfg_valid stays 1; no word is lost or duplicated.
- Back-to-back frames with idx 0 then idx 19 → strobes 20'h00001 then 20'h80000, never overlapping; frame_count=2; second frame's strobe begins 9 cycles after the first's.
- Async reset: assert resetn=0 during the 2nd STROBE cycle → FrameStrobe drops to 0 before the next CLK edge. After release: state IDLE, FrameData=0, cfg_ready=1.
- Counter wrap: preload via 65536 frames, or force frame_count=16'hFFFF → after one more frame, frame_count=0.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the frame column config loader: FSM encoding and
// header field layout of the 32-bit configuration stream.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 24;
  localparam int IDX_MSB = 4;
  localparam int IDX_LSB = 0;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of a frame index, gated by an enable. Reset clears
// the lines asynchronously so a latch enable never outlives reset.
module frame_strobe_decoder #(
  parameter int NUM_OUT = 20,
  parameter int IDX_W   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [NUM_OUT-1:0] o_strobe
);

  logic [NUM_OUT-1:0] r_strobe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        r_strobe[i] <= i_en && (i_idx == IDX_W'(i));
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/frame_config_loader.sv
// Assembles one frame column from a header + NumRows data words and pulses a
// one-hot FrameStrobe with one cycle of data setup before and hold after.
module frame_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter int         NumRows         = 4,
  parameter int         StrobeCycles    = 2,
  parameter logic [7:0] SyncByte        = SYNC_BYTE
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [31:0]                        cfg_data,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic                               err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               cfg_err,
  output logic [15:0]                        frame_count
);

  localparam int          RW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int          SCW   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [31:0] MAX_F = MaxFramesPerCol;

  state_t                             r_state, w_next;
  logic [RW-1:0]                      r_row;
  logic [IDX_W-1:0]                   r_idx;
  logic [SCW-1:0]                     r_scnt;
  logic [NumRows*FrameBitsPerRow-1:0] r_frame;
  logic [15:0]                        r_count;
  logic                               r_err;

  logic w_xfer, w_hdr_ok, w_last_row;
  logic [31:0] w_idx_ext;

  assign cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign busy       = (r_state != ST_IDLE);
  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_idx_ext  = 32'(cfg_data[IDX_MSB:IDX_LSB]);
  assign w_hdr_ok   = (cfg_data[TAG_MSB:TAG_LSB] == SyncByte) && (w_idx_ext < MAX_F);
  assign w_last_row = (r_row == RW'(NumRows - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && w_hdr_ok)   w_next = ST_LOAD;
      ST_LOAD:   if (w_xfer && w_last_row) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_STROBE;
      ST_STROBE: if (r_scnt == '0)         w_next = ST_HOLD;
      ST_HOLD:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_idx   <= '0;
      r_scnt  <= '0;
      r_frame <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_IDLE && w_xfer && w_hdr_ok) begin
        r_idx <= cfg_data[IDX_MSB:IDX_LSB];
        r_row <= '0;
      end else if (r_state == ST_LOAD && w_xfer) begin
        r_row <= r_row + 1'b1;
      end

      // Frame data only ever changes while loading, so it is stable through
      // setup, strobe and hold and retained while idle.
      if (r_state == ST_LOAD && w_xfer) begin
        for (int r = 0; r < NumRows; r++)
          if (r_row == RW'(r))
            r_frame[r*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
      end

      if (r_state == ST_SETUP)
        r_scnt <= SCW'(StrobeCycles - 1);
      else if (r_state == ST_STROBE && r_scnt != '0)
        r_scnt <= r_scnt - 1'b1;

      if (r_state == ST_STROBE && w_next == ST_HOLD)
        r_count <= r_count + 16'd1;

      // A bad header in the same cycle as a clear still reports the error.
      if (r_state == ST_IDLE && w_xfer && !w_hdr_ok)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  // Decoding from next state makes the registered strobe line up with STROBE.
  frame_strobe_decoder #(
    .NUM_OUT (MaxFramesPerCol),
    .IDX_W   (IDX_W)
  ) u_strobe_dec (
    .i_clk    (CLK),
    .i_rst_n  (resetn),
    .i_en     (w_next == ST_STROBE),
    .i_idx    (r_idx),
    .o_strobe (FrameStrobe)
  );

  assign FrameData   = r_frame;
  assign frame_count = r_count;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader: expected frames are queued as they
// are sent and compared when the strobe appears.
module tb_frame_config_loader;

  localparam int NR = 4;
  localparam int SC = 2;

  logic         CLK = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  cfg_data = '0;
  logic         cfg_valid = 1'b0;
  logic         err_clr = 1'b0;
  logic         cfg_ready;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic         cfg_err;
  logic [15:0]  frame_count;

  frame_config_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .err_clr     (err_clr),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] data;
    logic [19:0]  strobe;
    logic [15:0]  count;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  int           rise_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic [127:0] m_data = '0;
  logic [15:0]  m_count = '0;
  int           last_waits = 0;
  int           hdr_waits = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  logic [19:0] prev_strobe = '0;
  logic        prev_busy = 1'b0;
  logic        prev_ready = 1'b0;
  int          hi_len = 0;

  always @(negedge CLK) begin
    if (!mon_en) begin
      hi_len = 0;
    end else begin
      chk("onehot0", 128'($onehot0(FrameStrobe)), 128'(1));
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        if (sb.size() == 0) begin
          chk("unexp_strobe", 128'(FrameStrobe), 128'(0));
        end else begin
          cur = sb.pop_front();
          chk("setup_busy", 128'(prev_busy), 128'(1));
          chk("setup_ready", 128'(prev_ready), 128'(0));
          chk("strobe", 128'(FrameStrobe), 128'(cur.strobe));
          chk("data", FrameData, cur.data);
          rise_q.push_back(cyc);
        end
        hi_len = 1;
      end else if (FrameStrobe != '0) begin
        hi_len++;
        chk("strobe_stable", 128'(FrameStrobe), 128'(cur.strobe));
      end else if (prev_strobe != '0) begin
        chk("strobe_len", 128'(hi_len), 128'(SC));
        chk("hold_count", 128'(frame_count), 128'(cur.count));
        chk("hold_busy", 128'(busy), 128'(1));
        chk("hold_data", FrameData, cur.data);
      end
    end
    prev_strobe = mon_en ? FrameStrobe : '0;
    prev_busy   = busy;
    prev_ready  = cfg_ready;
  end

  task automatic send(input logic [31:0] d, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      @(negedge CLK);
      cfg_valid = 1'b0;
    end
    @(negedge CLK);
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 128'(n), 128'(0));
    last_waits = n;
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    cfg_valid = 1'b0;
    cfg_data  = $urandom();
  endtask

  task automatic frame(input logic [4:0] idx, input logic [127:0] d, input bit gap);
    exp_t e;
    m_data  = d;
    m_count = m_count + 16'd1;
    e.data   = d;
    e.strobe = 20'(1) << idx;
    e.count  = m_count;
    sb.push_back(e);
    send({8'hA5, 19'($urandom()), idx}, 1'b0);
    hdr_waits = last_waits;
    for (int r = 0; r < NR; r++) send(d[r*32 +: 32], gap);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_strobe", 128'(FrameStrobe), 128'(0));
    chk("rst_data", FrameData, 128'(0));
    chk("rst_count", 128'(frame_count), 128'(0));
    chk("rst_err", 128'(cfg_err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(cfg_ready), 128'(1));
    resetn = 1'b1;
    mon_en = 1'b1;

    // nominal frame
    frame(5'd3, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0);
    idle();
    repeat (6) @(negedge CLK);
    chk("nom_count", 128'(frame_count), 128'(m_count));
    chk("nom_busy", 128'(busy), 128'(0));
    chk("nom_data", FrameData, m_data);

    // bad headers: wrong tag, then out-of-range index
    send(32'h5A00_0001, 1'b0);
    idle();
    chk("err_tag", 128'(cfg_err), 128'(1));
    @(negedge CLK); err_clr = 1'b1;
    @(negedge CLK); err_clr = 1'b0;
    chk("err_clr1", 128'(cfg_err), 128'(0));
    send(32'hA500_0014, 1'b0);
    idle();
    chk("err_idx", 128'(cfg_err), 128'(1));
    chk("err_busy", 128'(busy), 128'(0));
    chk("err_data", FrameData, m_data);
    @(negedge CLK);
    cfg_valid = 1'b1; cfg_data = 32'h0000_0007; err_clr = 1'b1;
    @(negedge CLK);
    cfg_valid = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", 128'(cfg_err), 128'(1));
    @(negedge CLK); err_clr = 1'b1;
    @(negedge CLK); err_clr = 1'b0;
    chk("err_clr2", 128'(cfg_err), 128'(0));

    // stalled load, then back-to-back frames with valid held high
    frame(5'd7, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b1);
    frame(5'd0, {32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321, 32'hCAFE_BABE}, 1'b0);
    chk("b2b_waits0", 128'(hdr_waits), 128'(4));
    frame(5'd19, {32'hFFFF_0000, 32'h0000_FFFF, 32'h5555_AAAA, 32'hAAAA_5555}, 1'b0);
    chk("b2b_waits19", 128'(hdr_waits), 128'(4));
    idle();
    repeat (8) @(negedge CLK);
    chk("b2b_count", 128'(frame_count), 128'(m_count));
    chk("rise_cnt", 128'(rise_q.size()), 128'(4));
    if (rise_q.size() >= 3) begin
      chk("period_a", 128'(rise_q[2] - rise_q[1]), 128'(9));
      chk("period_b", 128'(rise_q[3] - rise_q[2]), 128'(9));
    end

    // async reset during the second strobe cycle
    mon_en = 1'b0;
    frame(5'd5, {4{32'h7777_7777}}, 1'b0);
    idle();
    n = 0;
    while (FrameStrobe == '0 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 30) chk("rst_wait_timeout", 128'(n), 128'(0));
    chk("pre_rst_strobe", 128'(FrameStrobe), 128'(20'h00020));
    @(posedge CLK);
    #1 resetn = 1'b0;
    #1 chk("async_strobe", 128'(FrameStrobe), 128'(0));
    sb.delete();
    rise_q.delete();
    m_data  = '0;
    m_count = '0;
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_ready", 128'(cfg_ready), 128'(1));
    chk("post_rst_data", FrameData, m_data);
    chk("post_rst_count", 128'(frame_count), 128'(m_count));
    mon_en = 1'b1;

    // counter wrap
    @(negedge CLK);
    force dut.r_count = 16'hFFFF;
    @(negedge CLK);
    release dut.r_count;
    @(negedge CLK);
    chk("pre_wrap", 128'(frame_count), 128'(16'hFFFF));
    m_count = 16'hFFFF;
    frame(5'd9, {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000}, 1'b0);
    idle();
    repeat (6) @(negedge CLK);
    chk("wrap_count", 128'(frame_count), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
